// File: rtl/pingpong_bram.sv
// Double-buffered block RAM: a producer fills one bank while a consumer drains the other.
// Ownership moves between the two sides through write_done/read_done handshakes.
module pingpong_bram #(
    parameter int unsigned Width     = 8,
    parameter int unsigned DepthBits = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 write_en_i,
    input  logic [DepthBits-1:0] write_addr_i,
    input  logic [Width-1:0]     write_di_i,
    input  logic                 write_done_i,
    output logic                 wr_ready_o,
    input  logic                 read_en_i,
    input  logic [DepthBits-1:0] read_addr_i,
    output logic [Width-1:0]     read_do_o,
    output logic                 read_valid_o,
    input  logic                 read_done_i,
    output logic                 rd_ready_o,
    output logic [DepthBits:0]   read_len_o,
    output logic                 overrun_o,
    output logic                 underrun_o
);

    localparam int unsigned Depth = 2 ** DepthBits;
    localparam logic [DepthBits:0] LenMax = (DepthBits + 1)'(Depth);

    logic [Width-1:0] ram0 [Depth];
    logic [Width-1:0] ram1 [Depth];

    logic [1:0]         full_q, full_d;
    logic               wsel_q, wsel_d;
    logic               rsel_q, rsel_d;
    logic [DepthBits:0] len0_q, len0_d;
    logic [DepthBits:0] len1_q, len1_d;
    logic               overrun_q, overrun_d;
    logic               underrun_q, underrun_d;
    logic [Width-1:0]   read_do_q;
    logic               read_valid_q;

    logic wr_ready, rd_ready;
    logic wr_fire, wdone_fire, rd_fire, rdone_fire;

    assign wr_ready   = !full_q[wsel_q];
    assign rd_ready   = full_q[rsel_q];
    assign wr_fire    = write_en_i && wr_ready;
    assign wdone_fire = write_done_i && wr_ready;
    assign rd_fire    = read_en_i && rd_ready;
    assign rdone_fire = read_done_i && rd_ready;

    function automatic logic [DepthBits:0] len_inc(input logic [DepthBits:0] len);
        return (len == LenMax) ? len : len + 1'b1;
    endfunction

    always_comb begin
        full_d     = full_q;
        wsel_d     = wsel_q;
        rsel_d     = rsel_q;
        len0_d     = len0_q;
        len1_d     = len1_q;
        overrun_d  = overrun_q | ((write_en_i | write_done_i) & !wr_ready);
        underrun_d = underrun_q | ((read_en_i | read_done_i) & !rd_ready);

        if (wr_fire) begin
            if (wsel_q) len1_d = len_inc(len1_q);
            else        len0_d = len_inc(len0_q);
        end
        if (wdone_fire) begin
            full_d[wsel_q] = 1'b1;
            wsel_d         = !wsel_q;
        end
        // Length is cleared when a bank is released, so any bank the producer
        // swaps onto starts at zero without disturbing a bank still being read.
        if (rdone_fire) begin
            full_d[rsel_q] = 1'b0;
            rsel_d         = !rsel_q;
            if (rsel_q) len1_d = '0;
            else        len0_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            full_q     <= '0;
            wsel_q     <= 1'b0;
            rsel_q     <= 1'b0;
            len0_q     <= '0;
            len1_q     <= '0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            wsel_q     <= wsel_d;
            rsel_q     <= rsel_d;
            len0_q     <= len0_d;
            len1_q     <= len1_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    // Storage arrays: no reset so they map onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_fire && !reset_i && !wsel_q) ram0[write_addr_i] <= write_di_i;
        if (wr_fire && !reset_i && wsel_q)  ram1[write_addr_i] <= write_di_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            read_do_q    <= '0;
            read_valid_q <= 1'b0;
        end else if (rd_fire) begin
            read_do_q    <= rsel_q ? ram1[read_addr_i] : ram0[read_addr_i];
            read_valid_q <= 1'b1;
        end else begin
            read_valid_q <= 1'b0;
        end
    end

    assign wr_ready_o   = wr_ready;
    assign rd_ready_o   = rd_ready;
    assign read_len_o   = rsel_q ? len1_q : len0_q;
    assign read_do_o    = read_do_q;
    assign read_valid_o = read_valid_q;
    assign overrun_o    = overrun_q;
    assign underrun_o   = underrun_q;

endmodule
